axi_sram_slave: RTL and testbench
=================================

Name: axi_sram_slave

Overview:
- AXI4 responder (slave) backed by an internal word-addressed SRAM array.
- Serves the LSU/IFU AXI4 master ports in simulation and SoC bring-up.
- Read and write channels run as independent state machines.
- Supports FIXED/INCR bursts, byte strobes and a programmable read latency.
- Returns full 32-bit words; the master extracts bytes/halves using addr[1:0].

Parameters:
- BASE_ADDR, 32'h8000_0000: byte address of array word 0.
- DEPTH_WORDS, 1024: number of 32-bit words; must be a power of two.
- READ_LATENCY, 1: idle cycles between AR handshake and first rvalid; 0 allowed, max 15.

Ports:
clock  in  1  clock, all logic on posedge
reset  in  1  synchronous active-high reset
araddr  in  32  read address
arvalid  in  1  read address valid
arready  out  1  read address ready
arid  in  4  read ID
arlen  in  8  beats-1
arsize  in  3  bytes/beat = 1<<arsize
arburst  in  2  00 FIXED, 01 INCR, 10 WRAP
rdata  out  32  read data word
rresp  out  2  00 OKAY, 10 SLVERR
rlast  out  1  final beat
rid  out  4  echoed arid
rvalid  out  1  read data valid
rready  in  1  master accepts read data
awaddr/awid/awlen/awsize/awburst  in  32/4/8/3/2  write address fields, same encoding as AR
awvalid  in  1  write address valid
awready  out  1  write address ready
wdata  in  32  write data
wstrb  in  4  byte enables
wlast  in  1  final write beat
wvalid  in  1  write data valid
wready  out  1  write data ready
bresp  out  2  write response
bid  out  4  echoed awid
bvalid  out  1  write response valid
bready  in  1  master accepts response

Behaviour:
- Reset values: arready=1, awready=1; wready, rvalid, bvalid, rlast=0; rdata, rresp, rid, bresp, bid=0.
- Array contents are not reset.
- Reset mid-transaction aborts it. Writes already committed remain in the array.
- Read FSM: R_IDLE, R_WAIT, R_DATA.
  - R_IDLE: arready=1. On arvalid&arready, latch id/addr/len/size/burst, clear beat counter, load latency counter.
  - After the AR handshake: go to R_WAIT if READ_LATENCY>0, else R_DATA next cycle.
  - R_WAIT: arready=0. Count READ_LATENCY cycles, then go to R_DATA.
  - R_DATA: rvalid=1; rdata, rresp, rlast=(beat==len) and rid are registered and held stable until rready.
  - On rvalid&rready with rlast: go to R_IDLE; arready rises the next cycle.
  - On rvalid&rready without rlast: advance the address, increment beat, present the next beat back-to-back (no further latency).
- Write FSM: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: awready=1, wready=0. W data presented before AW waits.
  - On aw handshake: latch AW fields, clear beat and the sticky error flag, go to W_DATA.
  - W_DATA: wready=1. On each w handshake, write byte lanes with wstrb[i]=1 at the current word, unless the beat is erroneous.
  - After each beat: advance the address and increment beat. When beat==len, go to W_RESP.
  - If wlast != (beat==len) on any beat, set SLVERR. The burst still ends at beat==len.
  - W_RESP: bvalid=1, bid=latched id, bresp=error?2'b10:2'b00. Hold until bready, then go to W_IDLE.
- Address advance: INCR adds (1<<size); FIXED keeps the address. The word index is (addr-BASE_ADDR)>>2.
- Error conditions (per beat):
  - The address is outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS).
  - size>2.
  - burst==WRAP or 11.
  - Read error beats return rdata=0 and rresp=10. Write error beats write nothing and make bresp=10.
  - Remaining beats of the burst still complete.
- Read and write run concurrently. If a write commits in the same cycle that rdata is captured for the same word, rdata returns the old value (read-before-write).
- Single-beat LSU traffic (len=0) behaves as a burst with rlast/wlast on the first beat.

Test Plan:
- Reset, then AR addr 0x8000_0010 len0 size2 with READ_LATENCY=1 → arready=1; rvalid rises 2 cycles after the handshake; rresp=00, rlast=1, rid echoed.
- AW 0x8000_0004 + W 0xAABBCCDD wstrb 0100, then read 0x8000_0004 (old word 0) → rdata=0x00BB0000, bresp=00, bvalid held until bready.
- INCR read len=3 size2 at 0x8000_0020 with rready toggling 1-0-1 → 4 beats at words 8..11; rlast only on beat 4; rdata stable while rready=0.
- Read 0x7FFF_FFFC and write 0x8000_1000 with DEPTH_WORDS=1024 → rresp=10, rdata=0; bresp=10; array unchanged.
- Write len=1 with wlast on beat 1 → bresp=10, both beats written. WRAP burst read → every beat rresp=10.
- Concurrent AR and AW in the same cycle to different words → both accepted that cycle; both responses correct and independent.

Source files
------------

// File: rtl/axi_sram_slave.sv
// AXI4 responder backed by a word-addressed SRAM array.
//
// Read and write channels are independent FSMs. FIXED and INCR bursts are served;
// WRAP/reserved bursts, sizes above 4 bytes and addresses outside the array give
// SLVERR per beat. Reads always return the full 32-bit word.
//
// Ports:
//   clock, reset                  clock and synchronous active-high reset
//   ar*  / r*                     read address / read data channels
//   aw*  / w* / b*                write address / write data / write response channels
module axi_sram_slave #(
  parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  // Read address channel
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  input  logic [3:0]  arid,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  // Read data channel
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic [3:0]  rid,
  output logic        rvalid,
  input  logic        rready,
  // Write address channel
  input  logic [31:0] awaddr,
  input  logic [3:0]  awid,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        awvalid,
  output logic        awready,
  // Write data channel
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  // Write response channel
  output logic [1:0]  bresp,
  output logic [3:0]  bid,
  output logic        bvalid,
  input  logic        bready
);

  localparam int unsigned IdxW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [63:0] SpanBytes = 64'(DEPTH_WORDS) << 2;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  // A beat is erroneous when out of range, wider than a word, or not FIXED/INCR.
  function automatic logic beat_err(input logic [31:0] addr, input logic [2:0] size,
                                    input logic [1:0] burst);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    return (64'(off) >= SpanBytes) || (size > 3'd2) || burst[1];
  endfunction

  function automatic logic [IdxW-1:0] word_idx(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    return IdxW'(off >> 2);
  endfunction

  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [2:0] size,
                                            input logic [1:0] burst);
    return (burst == 2'b01) ? addr + (32'd1 << size) : addr;
  endfunction

  logic [31:0] mem [DEPTH_WORDS];

  // ---------------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {RIdle, RWait, RData} rd_state_e;

  rd_state_e   rd_state_q, rd_state_d;
  logic [31:0] ar_addr_q;
  logic [3:0]  ar_id_q;
  logic [7:0]  ar_len_q;
  logic [2:0]  ar_size_q;
  logic [1:0]  ar_burst_q;
  logic [7:0]  rd_beat_q;
  logic [3:0]  rd_lat_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;

  logic        ar_hs, r_hs, rd_last;
  logic        rd_fetch;
  logic [31:0] fetch_addr;
  logic [2:0]  fetch_size;
  logic [1:0]  fetch_burst;

  assign ar_hs   = arvalid && arready;
  assign r_hs    = rvalid && rready;
  assign rd_last = (rd_beat_q == ar_len_q);

  always_ff @(posedge clock) begin
    if (reset) rd_state_q <= RIdle;
    else       rd_state_q <= rd_state_d;
  end

  always_comb begin
    rd_state_d = rd_state_q;
    unique case (rd_state_q)
      RIdle: if (ar_hs) rd_state_d = (READ_LATENCY == 0) ? RData : RWait;
      RWait: if (rd_lat_q <= 4'd1) rd_state_d = RData;
      RData: if (r_hs && rd_last) rd_state_d = RIdle;
      default: rd_state_d = RIdle;
    endcase
  end

  always_comb begin
    arready = (rd_state_q == RIdle);
    rvalid  = (rd_state_q == RData);
    rlast   = rvalid && rd_last;
    rid     = ar_id_q;
    rdata   = rdata_q;
    rresp   = rresp_q;
  end

  // Selects which beat address feeds the rdata register this cycle, if any.
  always_comb begin
    rd_fetch    = 1'b0;
    fetch_addr  = ar_addr_q;
    fetch_size  = ar_size_q;
    fetch_burst = ar_burst_q;
    unique case (rd_state_q)
      RIdle: begin
        if (ar_hs && (READ_LATENCY == 0)) begin
          rd_fetch    = 1'b1;
          fetch_addr  = araddr;
          fetch_size  = arsize;
          fetch_burst = arburst;
        end
      end
      RWait: rd_fetch = (rd_lat_q <= 4'd1);
      RData: begin
        if (r_hs && !rd_last) begin
          rd_fetch   = 1'b1;
          fetch_addr = next_addr(ar_addr_q, ar_size_q, ar_burst_q);
        end
      end
      default: rd_fetch = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ar_addr_q  <= '0;
      ar_id_q    <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
      rd_beat_q  <= '0;
      rd_lat_q   <= '0;
      rdata_q    <= '0;
      rresp_q    <= RespOkay;
    end else begin
      if (ar_hs) begin
        ar_addr_q  <= araddr;
        ar_id_q    <= arid;
        ar_len_q   <= arlen;
        ar_size_q  <= arsize;
        ar_burst_q <= arburst;
        rd_beat_q  <= '0;
        rd_lat_q   <= 4'(READ_LATENCY);
      end
      if (rd_state_q == RWait) rd_lat_q <= rd_lat_q - 4'd1;
      if ((rd_state_q == RData) && r_hs && !rd_last) begin
        ar_addr_q <= next_addr(ar_addr_q, ar_size_q, ar_burst_q);
        rd_beat_q <= rd_beat_q + 8'd1;
      end
      // Array read here sees pre-write contents, giving read-before-write ordering.
      if (rd_fetch) begin
        if (beat_err(fetch_addr, fetch_size, fetch_burst)) begin
          rdata_q <= '0;
          rresp_q <= RespSlvErr;
        end else begin
          rdata_q <= mem[word_idx(fetch_addr)];
          rresp_q <= RespOkay;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Write channel
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {WIdle, WData, WResp} wr_state_e;

  wr_state_e   wr_state_q, wr_state_d;
  logic [31:0] aw_addr_q;
  logic [3:0]  aw_id_q;
  logic [7:0]  aw_len_q;
  logic [2:0]  aw_size_q;
  logic [1:0]  aw_burst_q;
  logic [7:0]  wr_beat_q;
  logic        wr_err_q;

  logic aw_hs, w_hs, wr_last, wr_beat_bad;

  assign aw_hs       = awvalid && awready;
  assign w_hs        = wvalid && wready;
  assign wr_last     = (wr_beat_q == aw_len_q);
  assign wr_beat_bad = beat_err(aw_addr_q, aw_size_q, aw_burst_q);

  always_ff @(posedge clock) begin
    if (reset) wr_state_q <= WIdle;
    else       wr_state_q <= wr_state_d;
  end

  always_comb begin
    wr_state_d = wr_state_q;
    unique case (wr_state_q)
      WIdle: if (aw_hs) wr_state_d = WData;
      WData: if (w_hs && wr_last) wr_state_d = WResp;
      WResp: if (bready) wr_state_d = WIdle;
      default: wr_state_d = WIdle;
    endcase
  end

  always_comb begin
    awready = (wr_state_q == WIdle);
    wready  = (wr_state_q == WData);
    bvalid  = (wr_state_q == WResp);
    bid     = aw_id_q;
    bresp   = (bvalid && wr_err_q) ? RespSlvErr : RespOkay;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      aw_addr_q  <= '0;
      aw_id_q    <= '0;
      aw_len_q   <= '0;
      aw_size_q  <= '0;
      aw_burst_q <= '0;
      wr_beat_q  <= '0;
      wr_err_q   <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_addr_q  <= awaddr;
        aw_id_q    <= awid;
        aw_len_q   <= awlen;
        aw_size_q  <= awsize;
        aw_burst_q <= awburst;
        wr_beat_q  <= '0;
        wr_err_q   <= 1'b0;
      end
      if (w_hs) begin
        // A wlast mismatch flags the response but the data is still committed.
        if (wr_beat_bad || (wlast != wr_last)) wr_err_q <= 1'b1;
        aw_addr_q <= next_addr(aw_addr_q, aw_size_q, aw_burst_q);
        wr_beat_q <= wr_beat_q + 8'd1;
      end
    end
  end

  // Array contents survive reset; only the write strobe is gated by it.
  always_ff @(posedge clock) begin
    if (!reset && w_hs && !wr_beat_bad) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[word_idx(aw_addr_q)][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
module tb_axi_sram_slave;

  localparam logic [31:0] Base  = 32'h8000_0000;
  localparam int          Depth = 1024;
  localparam int          Lat   = 1;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  rid;
  logic        rvalid;
  logic        rready = 1'b1;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic [3:0]  bid;
  logic        bvalid;
  logic        bready = 1'b1;

  axi_sram_slave #(
    .BASE_ADDR   (Base),
    .DEPTH_WORDS (Depth),
    .READ_LATENCY(Lat)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .araddr (araddr),
    .arvalid(arvalid),
    .arready(arready),
    .arid   (arid),
    .arlen  (arlen),
    .arsize (arsize),
    .arburst(arburst),
    .rdata  (rdata),
    .rresp  (rresp),
    .rlast  (rlast),
    .rid    (rid),
    .rvalid (rvalid),
    .rready (rready),
    .awaddr (awaddr),
    .awid   (awid),
    .awlen  (awlen),
    .awsize (awsize),
    .awburst(awburst),
    .awvalid(awvalid),
    .awready(awready),
    .wdata  (wdata),
    .wstrb  (wstrb),
    .wlast  (wlast),
    .wvalid (wvalid),
    .wready (wready),
    .bresp  (bresp),
    .bid    (bid),
    .bvalid (bvalid),
    .bready (bready)
  );

  always #5 clock = ~clock;

  // Reference model and scoreboard queues
  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } rbeat_t;

  typedef struct {
    logic [1:0] resp;
    logic [3:0] id;
  } bexp_t;

  logic [31:0] ref_mem [Depth];
  rbeat_t      rq[$];
  bexp_t       bq[$];
  logic [31:0] wbuf_data [256];
  logic [3:0]  wbuf_strb [256];

  int  checks = 0;
  int  passes = 0;
  bit  rr_rand = 1'b0;
  bit  br_rand = 1'b0;
  time ar_hs_t, aw_hs_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic timeout(input string name);
    checks++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  function automatic bit addr_ok(input logic [31:0] a);
    logic [31:0] off;
    off = a - Base;
    return off < 32'(Depth * 4);
  endfunction

  function automatic bit is_bad(input logic [31:0] a, input logic [2:0] s, input logic [1:0] b);
    return !addr_ok(a) || (s > 3'd2) || (b == 2'b10) || (b == 2'b11);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - Base) >> 2);
  endfunction

  task automatic predict_read(input logic [31:0] addr, input logic [3:0] id, input int len,
                              input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] a;
    rbeat_t      e;
    a = addr;
    for (int b = 0; b <= len; b++) begin
      e.id   = id;
      e.last = (b == len);
      if (is_bad(a, size, burst)) begin
        e.data = 32'h0;
        e.resp = 2'b10;
      end else begin
        e.data = ref_mem[widx(a)];
        e.resp = 2'b00;
      end
      rq.push_back(e);
      if (burst == 2'b01) a = a + (32'd1 << size);
    end
  endtask

  task automatic model_write(input logic [31:0] addr, input logic [3:0] id, input int len,
                             input logic [2:0] size, input logic [1:0] burst, input int badbeat);
    logic [31:0] a;
    bit          err;
    bit          lst;
    bexp_t       e;
    a   = addr;
    err = 1'b0;
    for (int b = 0; b <= len; b++) begin
      lst = (b == len) ^ (b == badbeat);
      if (lst != (b == len)) err = 1'b1;
      if (is_bad(a, size, burst)) err = 1'b1;
      else begin
        for (int i = 0; i < 4; i++)
          if (wbuf_strb[b][i]) ref_mem[widx(a)][8*i +: 8] = wbuf_data[b][8*i +: 8];
      end
      if (burst == 2'b01) a = a + (32'd1 << size);
    end
    e.resp = err ? 2'b10 : 2'b00;
    e.id   = id;
    bq.push_back(e);
  endtask

  task automatic send_ar(input logic [31:0] addr, input logic [3:0] id, input int len,
                         input logic [2:0] size, input logic [1:0] burst);
    bit ok;
    int lat;
    predict_read(addr, id, len, size, burst);
    @(posedge clock); #1;
    araddr = addr; arid = id; arlen = 8'(len); arsize = size; arburst = burst; arvalid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clock);
      if (arready) begin ok = 1'b1; ar_hs_t = $time; break; end
      @(posedge clock); #1;
    end
    if (!ok) timeout("ar_handshake");
    @(posedge clock); #1;
    arvalid = 1'b0;
    ok  = 1'b0;
    lat = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clock);
      lat++;
      if (rvalid) begin ok = 1'b1; break; end
    end
    if (!ok) timeout("rvalid_wait");
    else check("ar_to_rvalid_cycles", 32'(lat), 32'(Lat + 1));
  endtask

  task automatic send_write(input logic [31:0] addr, input logic [3:0] id, input int len,
                            input logic [2:0] size, input logic [1:0] burst, input int badbeat);
    bit ok;
    model_write(addr, id, len, size, burst, badbeat);
    @(posedge clock); #1;
    awaddr = addr; awid = id; awlen = 8'(len); awsize = size; awburst = burst; awvalid = 1'b1;
    // First W beat is offered together with AW and must wait for it.
    wdata = wbuf_data[0]; wstrb = wbuf_strb[0]; wlast = (len == 0) ^ (badbeat == 0);
    wvalid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clock);
      if (awready) begin ok = 1'b1; aw_hs_t = $time; break; end
      @(posedge clock); #1;
    end
    if (!ok) timeout("aw_handshake");
    @(posedge clock); #1;
    awvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      wdata  = wbuf_data[b];
      wstrb  = wbuf_strb[b];
      wlast  = (b == len) ^ (b == badbeat);
      wvalid = 1'b1;
      ok = 1'b0;
      for (int n = 0; n < 200; n++) begin
        @(negedge clock);
        if (wready) begin ok = 1'b1; break; end
        @(posedge clock); #1;
      end
      if (!ok) begin timeout("w_handshake"); break; end
      @(posedge clock); #1;
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clock);
      if (rq.size() == 0 && bq.size() == 0 && !rvalid && !bvalid) begin ok = 1'b1; break; end
    end
    if (!ok) timeout("drain");
  endtask

  // Ready drivers
  always @(posedge clock) begin
    #1;
    rready = rr_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
    bready = br_rand ? ($urandom_range(0, 2) == 0) : 1'b1;
  end

  // R monitor: every presented beat must match the queue head until it is accepted.
  always @(negedge clock) begin
    if (!reset && rvalid) begin
      if (rq.size() == 0) timeout("r_unexpected_beat");
      else begin
        check("rdata", rdata, rq[0].data);
        check("rresp", 32'(rresp), 32'(rq[0].resp));
        check("rlast", 32'(rlast), 32'(rq[0].last));
        check("rid", 32'(rid), 32'(rq[0].id));
        if (rready) void'(rq.pop_front());
      end
    end
  end

  // B monitor
  always @(negedge clock) begin
    if (!reset && bvalid) begin
      if (bq.size() == 0) timeout("b_unexpected_resp");
      else begin
        check("bresp", 32'(bresp), 32'(bq[0].resp));
        check("bid", 32'(bid), 32'(bq[0].id));
        if (bready) void'(bq.pop_front());
      end
    end
  end

  initial begin
    logic [31:0] a;
    int          len, bb;
    logic [2:0]  sz;
    logic [1:0]  bu;

    reset   = 1'b1;
    arvalid = 1'b0; araddr = '0; arid = '0; arlen = '0; arsize = '0; arburst = '0;
    awvalid = 1'b0; awaddr = '0; awid = '0; awlen = '0; awsize = '0; awburst = '0;
    wvalid  = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_arready", 32'(arready), 32'd1);
    check("rst_awready", 32'(awready), 32'd1);
    check("rst_wready", 32'(wready), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rlast", 32'(rlast), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_rresp", 32'(rresp), 32'd0);
    check("rst_rid", 32'(rid), 32'd0);
    check("rst_bresp", 32'(bresp), 32'd0);
    check("rst_bid", 32'(bid), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Fill the whole array with known random data using four 256-beat INCR bursts.
    for (int k = 0; k < 4; k++) begin
      for (int b = 0; b < 256; b++) begin
        wbuf_data[b] = $urandom();
        wbuf_strb[b] = 4'hF;
      end
      send_write(Base + 32'(k * 1024), 4'(k), 255, 3'd2, 2'b01, -1);
      wait_idle();
    end

    // Single-beat read latency and id echo
    send_ar(Base + 32'h10, 4'h3, 0, 3'd2, 2'b01);
    wait_idle();

    // Byte-lane write over a zeroed word, then read back with slow bready
    wbuf_data[0] = 32'h0; wbuf_strb[0] = 4'hF;
    send_write(Base + 32'h4, 4'h1, 0, 3'd2, 2'b01, -1);
    wait_idle();
    br_rand = 1'b1;
    wbuf_data[0] = 32'hAABB_CCDD; wbuf_strb[0] = 4'b0100;
    send_write(Base + 32'h4, 4'h2, 0, 3'd2, 2'b01, -1);
    wait_idle();
    send_ar(Base + 32'h4, 4'h4, 0, 3'd2, 2'b01);
    wait_idle();
    check("word1_lane2_model", ref_mem[1], 32'h00BB_0000);

    // INCR burst with back-pressure
    rr_rand = 1'b1;
    send_ar(Base + 32'h20, 4'h5, 3, 3'd2, 2'b01);
    wait_idle();

    // Out-of-range read and write; word 0 must be untouched afterwards
    send_ar(32'h7FFF_FFFC, 4'h6, 0, 3'd2, 2'b01);
    wait_idle();
    wbuf_data[0] = 32'hDEAD_BEEF; wbuf_strb[0] = 4'hF;
    send_write(Base + 32'h1000, 4'h7, 0, 3'd2, 2'b01, -1);
    wait_idle();
    send_ar(Base, 4'h8, 0, 3'd2, 2'b01);
    wait_idle();

    // Early wlast: SLVERR but both beats committed
    wbuf_data[0] = 32'h1111_2222; wbuf_strb[0] = 4'hF;
    wbuf_data[1] = 32'h3333_4444; wbuf_strb[1] = 4'hF;
    send_write(Base + 32'h40, 4'h9, 1, 3'd2, 2'b01, 0);
    wait_idle();
    send_ar(Base + 32'h40, 4'hA, 1, 3'd2, 2'b01);
    wait_idle();

    // WRAP, reserved burst and oversize reads
    send_ar(Base + 32'h30, 4'hB, 3, 3'd2, 2'b10);
    wait_idle();
    send_ar(Base + 32'h30, 4'hC, 1, 3'd2, 2'b11);
    wait_idle();
    send_ar(Base, 4'hD, 0, 3'd3, 2'b01);
    wait_idle();

    // FIXED write merging strobes into one word, FIXED read-back
    wbuf_data[0] = 32'h0000_00A1; wbuf_strb[0] = 4'b0001;
    wbuf_data[1] = 32'h0000_B200; wbuf_strb[1] = 4'b0010;
    wbuf_data[2] = 32'hC3D4_0000; wbuf_strb[2] = 4'b1100;
    send_write(Base + 32'h50, 4'hE, 2, 3'd2, 2'b00, -1);
    wait_idle();
    send_ar(Base + 32'h50, 4'hF, 2, 3'd2, 2'b00);
    wait_idle();

    // Bursts running off the top of the array
    send_ar(Base + 32'(Depth * 4 - 8), 4'h1, 3, 3'd2, 2'b01);
    wait_idle();
    for (int b = 0; b < 4; b++) begin wbuf_data[b] = $urandom(); wbuf_strb[b] = 4'hF; end
    send_write(Base + 32'(Depth * 4 - 4), 4'h2, 2, 3'd2, 2'b01, -1);
    wait_idle();
    send_ar(Base + 32'(Depth * 4 - 4), 4'h3, 0, 3'd2, 2'b01);
    wait_idle();

    // Concurrent AR and AW to different words
    wbuf_data[0] = 32'h5A5A_0F0F; wbuf_strb[0] = 4'hF;
    fork
      send_ar(Base + 32'h60, 4'h4, 0, 3'd2, 2'b01);
      send_write(Base + 32'h70, 4'h5, 0, 3'd2, 2'b01, -1);
    join
    check("ar_aw_same_cycle", 32'(ar_hs_t == aw_hs_t), 32'd1);
    wait_idle();
    send_ar(Base + 32'h70, 4'h6, 0, 3'd2, 2'b01);
    wait_idle();

    // Randomized traffic
    for (int t = 0; t < 60; t++) begin
      len = $urandom_range(0, 7);
      sz  = ($urandom_range(0, 99) < 85) ? 3'd2 : 3'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0:       bu = 2'b00;
        1:       bu = 2'($urandom_range(2, 3));
        default: bu = 2'b01;
      endcase
      case ($urandom_range(0, 7))
        0:       a = Base - 32'(4 * $urandom_range(1, 4));
        1:       a = Base + 32'(Depth * 4 - 4 * $urandom_range(1, 4));
        default: a = Base + 32'($urandom_range(0, Depth - 1) << 2);
      endcase
      if (sz < 3'd2) a = a + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) begin
        send_ar(a, 4'($urandom_range(0, 15)), len, sz, bu);
      end else begin
        for (int b = 0; b <= len; b++) begin
          wbuf_data[b] = $urandom();
          wbuf_strb[b] = 4'($urandom_range(0, 15));
        end
        bb = ($urandom_range(0, 9) == 0) ? $urandom_range(0, len) : -1;
        send_write(a, 4'($urandom_range(0, 15)), len, sz, bu, bb);
      end
      wait_idle();
    end

    check("r_queue_empty", 32'(rq.size()), 32'd0);
    check("b_queue_empty", 32'(bq.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
